// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: registered req/gnt arbiter for host (H) and CPU (C) sharing one memory port,
// with read-latency tracking and memory-clear sequencing. Define FAIR_ARB_EN for round-robin arbitration.
module mem_port_arbiter #(
    parameter int AW     = 12,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cpu_en,
    input  logic          i_h_req,
    input  logic          i_h_rw,
    input  logic [AW-1:0] i_h_addr,
    input  logic [DW-1:0] i_h_wdata,
    output logic          o_h_gnt,
    output logic          o_h_rvalid,
    output logic [DW-1:0] o_h_rdata,
    input  logic          i_c_req,
    input  logic          i_c_rw,
    input  logic [AW-1:0] i_c_addr,
    input  logic [DW-1:0] i_c_wdata,
    output logic          o_c_gnt,
    output logic          o_c_rvalid,
    output logic [DW-1:0] o_c_rdata,
    input  logic          i_clr_req,
    output logic          o_clr_done,
    output logic          o_mem_en,
    output logic          o_mem_rw,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic          o_mem_clr,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_busy
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_CLEAR} state_t;
    state_t     r_state;
    logic       r_owner_c;
    logic [2:0] r_cnt;
    logic       w_c_req;
    logic       w_req;
    logic       w_pick_c;
    assign w_c_req = i_c_req & i_cpu_en;
    assign w_req   = i_h_req | w_c_req;
`ifdef FAIR_ARB_EN
    logic r_prio_c;
    assign w_pick_c = w_c_req & (~i_h_req | r_prio_c);
`else
    assign w_pick_c = w_c_req & ~i_h_req;
`endif
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_owner_c   <= 1'b0;
            r_cnt       <= '0;
            o_h_gnt     <= 1'b0;
            o_h_rvalid  <= 1'b0;
            o_h_rdata   <= '0;
            o_c_gnt     <= 1'b0;
            o_c_rvalid  <= 1'b0;
            o_c_rdata   <= '0;
            o_clr_done  <= 1'b0;
            o_mem_en    <= 1'b0;
            o_mem_rw    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_clr   <= 1'b0;
            o_busy      <= 1'b0;
`ifdef FAIR_ARB_EN
            r_prio_c    <= 1'b0;
`endif
        end else begin
            o_h_gnt    <= 1'b0;
            o_c_gnt    <= 1'b0;
            o_h_rvalid <= 1'b0;
            o_c_rvalid <= 1'b0;
            o_mem_en   <= 1'b0;
            o_mem_clr  <= 1'b0;
            o_clr_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_clr_req) begin
                        r_state    <= S_CLEAR;
                        o_mem_clr  <= 1'b1;
                        o_clr_done <= 1'b1;
                        o_busy     <= 1'b1;
                    end else if (w_req) begin
                        // mem_rw/addr/wdata double as the latched request for the whole access
                        r_state     <= S_ISSUE;
                        r_owner_c   <= w_pick_c;
                        o_mem_en    <= 1'b1;
                        o_mem_rw    <= w_pick_c ? i_c_rw : i_h_rw;
                        o_mem_addr  <= w_pick_c ? i_c_addr : i_h_addr;
                        o_mem_wdata <= w_pick_c ? i_c_wdata : i_h_wdata;
                        o_h_gnt     <= ~w_pick_c;
                        o_c_gnt     <= w_pick_c;
                        o_busy      <= 1'b1;
`ifdef FAIR_ARB_EN
                        r_prio_c    <= ~w_pick_c;
`endif
                    end
                end
                S_ISSUE: begin
                    r_state <= o_mem_rw ? S_IDLE : S_WAIT;
                    o_busy  <= ~o_mem_rw;
                    r_cnt   <= 3'(RD_LAT - 1);
                end
                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= S_RESP;
                        if (r_owner_c) begin
                            o_c_rdata  <= i_mem_rdata;
                            o_c_rvalid <= 1'b1;
                        end else begin
                            o_h_rdata  <= i_mem_rdata;
                            o_h_rvalid <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter with RD_LAT=1 (memory model) and RD_LAT=3.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_en, h_req, h_rw, c_req, c_rw, clr_req;
    logic [11:0] h_addr, c_addr;
    logic [31:0] h_wdata, c_wdata, mem_rdata, mem_rdata3;
    logic        h_gnt, h_rvalid, c_gnt, c_rvalid, clr_done, mem_en, mem_rw, mem_clr, busy;
    logic [31:0] h_rdata, c_rdata, mem_wdata;
    logic [11:0] mem_addr;
    logic        h_gnt3, h_rvalid3, c_gnt3, c_rvalid3, clr_done3, mem_en3, mem_rw3, mem_clr3, busy3;
    logic [31:0] h_rdata3, c_rdata3, mem_wdata3;
    logic [11:0] mem_addr3;
    logic [31:0] mem [0:4095];
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(12), .DW(32), .RD_LAT(1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cpu_en(cpu_en),
        .i_h_req(h_req), .i_h_rw(h_rw), .i_h_addr(h_addr), .i_h_wdata(h_wdata),
        .o_h_gnt(h_gnt), .o_h_rvalid(h_rvalid), .o_h_rdata(h_rdata),
        .i_c_req(c_req), .i_c_rw(c_rw), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
        .o_c_gnt(c_gnt), .o_c_rvalid(c_rvalid), .o_c_rdata(c_rdata),
        .i_clr_req(clr_req), .o_clr_done(clr_done),
        .o_mem_en(mem_en), .o_mem_rw(mem_rw), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_clr(mem_clr), .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    mem_port_arbiter #(.AW(12), .DW(32), .RD_LAT(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cpu_en(cpu_en),
        .i_h_req(h_req), .i_h_rw(h_rw), .i_h_addr(h_addr), .i_h_wdata(h_wdata),
        .o_h_gnt(h_gnt3), .o_h_rvalid(h_rvalid3), .o_h_rdata(h_rdata3),
        .i_c_req(c_req), .i_c_rw(c_rw), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
        .o_c_gnt(c_gnt3), .o_c_rvalid(c_rvalid3), .o_c_rdata(c_rdata3),
        .i_clr_req(clr_req), .o_clr_done(clr_done3),
        .o_mem_en(mem_en3), .o_mem_rw(mem_rw3), .o_mem_addr(mem_addr3), .o_mem_wdata(mem_wdata3),
        .o_mem_clr(mem_clr3), .i_mem_rdata(mem_rdata3), .o_busy(busy3)
    );

    // one-cycle-latency synchronous memory for the RD_LAT=1 instance
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
        end else if (mem_en && mem_rw) begin
            mem[mem_addr] <= mem_wdata;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem_rdata = '0; mem_rdata3 = '0;
        rst_n = 1'b0; cpu_en = 1'b0; clr_req = 1'b0;
        h_req = 1'b0; h_rw = 1'b0; h_addr = '0; h_wdata = '0;
        c_req = 1'b0; c_rw = 1'b0; c_addr = '0; c_wdata = '0;
        step(); step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_h_gnt", {31'd0, h_gnt}, 32'd0);
        rst_n = 1'b1;
        step();

        // H write then read back
        h_req = 1'b1; h_rw = 1'b1; h_addr = 12'h010; h_wdata = 32'hDEADBEEF;
        step();
        check("wr_h_gnt", {31'd0, h_gnt}, 32'd1);
        check("wr_c_gnt", {31'd0, c_gnt}, 32'd0);
        check("wr_mem_en", {31'd0, mem_en}, 32'd1);
        check("wr_mem_rw", {31'd0, mem_rw}, 32'd1);
        check("wr_mem_addr", {20'd0, mem_addr}, 32'h010);
        check("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        h_req = 1'b0;
        step();
        check("wr_gnt_pulse", {31'd0, h_gnt}, 32'd0);
        check("wr_busy_idle", {31'd0, busy}, 32'd0);
        h_req = 1'b1; h_rw = 1'b0;
        step();
        check("rd_h_gnt", {31'd0, h_gnt}, 32'd1);
        check("rd_mem_rw", {31'd0, mem_rw}, 32'd0);
        h_req = 1'b0;
        step();
        check("rd_wait_rvalid", {31'd0, h_rvalid}, 32'd0);
        check("rd_wait_mem_en", {31'd0, mem_en}, 32'd0);
        check("rd_wait_busy", {31'd0, busy}, 32'd1);
        step();
        check("rd_h_rvalid", {31'd0, h_rvalid}, 32'd1);
        check("rd_h_rdata", h_rdata, 32'hDEADBEEF);
        check("rd_c_rvalid", {31'd0, c_rvalid}, 32'd0);
        step();
        check("rd_rvalid_pulse", {31'd0, h_rvalid}, 32'd0);
        check("rd_rdata_hold", h_rdata, 32'hDEADBEEF);

        // reset in the middle of a C read
        cpu_en = 1'b1; c_req = 1'b1; c_rw = 1'b0; c_addr = 12'h020;
        step();
        check("abort_c_gnt", {31'd0, c_gnt}, 32'd1);
        c_req = 1'b0;
        step();
        check("abort_busy_wait", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_c_rvalid", {31'd0, c_rvalid}, 32'd0);
        check("abort_h_rdata", h_rdata, 32'd0);
        check("abort_mem_addr", {20'd0, mem_addr}, 32'd0);
        check("abort_mem_en", {31'd0, mem_en}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_rvalid", {31'd0, c_rvalid}, 32'd0);
            check("abort_idle", {31'd0, busy}, 32'd0);
        end

        // both ports hold write requests
        h_req = 1'b1; h_rw = 1'b1; h_addr = 12'h001; h_wdata = 32'h1111;
        c_req = 1'b1; c_rw = 1'b1; c_addr = 12'h002; c_wdata = 32'h2222;
        for (int i = 0; i < 6; i++) begin
            logic [1:0] exp_gnt;
`ifdef FAIR_ARB_EN
            exp_gnt = (i % 2 == 1) ? 2'b00 : ((i % 4 == 0) ? 2'b10 : 2'b01);
`else
            exp_gnt = (i % 2 == 1) ? 2'b00 : 2'b10;
`endif
            step();
            check("both_gnt", {30'd0, h_gnt, c_gnt}, {30'd0, exp_gnt});
        end
        h_req = 1'b0; c_req = 1'b0;
        step(); step();

        // cpu_en masks the C request
        cpu_en = 1'b0; c_req = 1'b1; c_rw = 1'b1; c_addr = 12'h003; c_wdata = 32'h3333;
        for (int i = 0; i < 10; i++) begin
            step();
            check("mask_c_gnt", {31'd0, c_gnt}, 32'd0);
            check("mask_mem_en", {31'd0, mem_en}, 32'd0);
        end
        cpu_en = 1'b1;
        step();
        check("unmask_c_gnt", {31'd0, c_gnt}, 32'd1);
        check("unmask_addr", {20'd0, mem_addr}, 32'h003);
        c_req = 1'b0;
        step();

        // clear request arrives during a C read
        c_req = 1'b1; c_rw = 1'b0; c_addr = 12'h010;
        step();
        check("clr_c_gnt", {31'd0, c_gnt}, 32'd1);
        c_req = 1'b0;
        step();
        clr_req = 1'b1; h_req = 1'b1; h_rw = 1'b1; h_addr = 12'h005; h_wdata = 32'h5555;
        step();
        check("clr_c_rvalid", {31'd0, c_rvalid}, 32'd1);
        check("clr_c_rdata", c_rdata, 32'hDEADBEEF);
        check("clr_early", {31'd0, mem_clr}, 32'd0);
        step();
        check("clr_idle_mem_clr", {31'd0, mem_clr}, 32'd0);
        check("clr_idle_h_gnt", {31'd0, h_gnt}, 32'd0);
        step();
        check("clr_mem_clr", {31'd0, mem_clr}, 32'd1);
        check("clr_done", {31'd0, clr_done}, 32'd1);
        check("clr_h_gnt", {31'd0, h_gnt}, 32'd0);
        clr_req = 1'b0;
        step();
        check("clr_after_done", {31'd0, clr_done}, 32'd0);
        check("clr_h_wait", {31'd0, h_gnt}, 32'd0);
        step();
        check("clr_h_gnt_late", {31'd0, h_gnt}, 32'd1);
        h_req = 1'b0;
        step(); step();

        // RD_LAT=3 read timing on the second instance
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        c_req = 1'b1; c_rw = 1'b0; c_addr = 12'hFFF;
        step();
        check("lat3_c_gnt", {31'd0, c_gnt3}, 32'd1);
        check("lat3_mem_en", {31'd0, mem_en3}, 32'd1);
        check("lat3_addr", {20'd0, mem_addr3}, 32'hFFF);
        c_req = 1'b0;
        step();
        check("lat3_en_pulse", {31'd0, mem_en3}, 32'd0);
        mem_rdata3 = 32'h11111111;
        step();
        check("lat3_w2_rvalid", {31'd0, c_rvalid3}, 32'd0);
        mem_rdata3 = 32'h22222222;
        step();
        check("lat3_w3_rvalid", {31'd0, c_rvalid3}, 32'd0);
        mem_rdata3 = 32'h33333333;
        step();
        check("lat3_c_rvalid", {31'd0, c_rvalid3}, 32'd1);
        check("lat3_c_rdata", c_rdata3, 32'h33333333);
        check("lat3_h_rvalid", {31'd0, h_rvalid3}, 32'd0);
        mem_rdata3 = 32'h44444444;
        step();
        check("lat3_rvalid_pulse", {31'd0, c_rvalid3}, 32'd0);
        check("lat3_rdata_hold", c_rdata3, 32'h33333333);
        check("lat3_idle", {31'd0, busy3}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
